regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the integer register file.
- Configurable read-port count, write-port count and depth.
- Per-port write-to-read bypass, plus an integrated scoreboard (busy bit per register) so issue logic can see whether an operand is ready.
- Sits between decode/issue and writeback; the scoreboard is set at issue and cleared at writeback.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, architectural register count (power of 2, >=2).
- AW, $clog2(NUM_REGS), register address width (derived, not overridden).
- NUM_RD, 2, read-port count (1..4).
- NUM_WR, 1, write-port count (1..2).
- RESET_VAL, '0, reset value of every register r1..NUM_REGS-1.

Ports:
- clk  in  1  clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies slice [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  read data per port (combinational).
- rd_ready  out  NUM_RD  operand-ready flag per port (combinational).
- wr_en  in  NUM_WR  write enable per write port.
- wr_addr  in  NUM_WR*AW  write destination per port.
- wr_data  in  NUM_WR*XLEN  write data per port.
- alloc_en  in  1  issue-side allocation; marks alloc_addr busy.
- alloc_addr  in  AW  register being allocated.
- par_err  out  NUM_RD  per-port parity error (see optional feature).
- par_err_sticky  out  1  latched OR of all par_err.
- par_err_clr  in  1  synchronous clear of par_err_sticky.

Behaviour:
- Reset (async assert, released synchronously by the environment):
  - regs r1..NUM_REGS-1 = RESET_VAL.
  - all busy bits = 0.
  - par_err_sticky = 0.
  - Reset asserted mid-write discards the write.
- Storage is r1..NUM_REGS-1 only. r0 is not stored: it reads 0, rd_ready=1, is never busy, and writes and allocs to r0 are ignored.
- Writes land at posedge. If several wr_en target the same non-zero register in one cycle, the highest port index wins. This is the same rule the bypass uses.
- Read port i, combinational, zero latency:
  - addr==0: rd_data=0, rd_ready=1.
  - else if any write port j has wr_en[j] && wr_addr[j]==addr: rd_data=wr_data of the highest such j; rd_ready=1.
  - else rd_data = stored value; rd_ready = ~busy[addr].
- Scoreboard update at posedge, per register r != 0:
  - set if alloc_en && alloc_addr==r.
  - else clear if any wr_en[j] && wr_addr[j]==r.
  - else hold.
- Alloc and writeback to the same register in the same cycle: alloc wins, so busy stays 1 and the data is still written (a new producer is in flight).
- Alloc to an already-busy register: it stays busy (no counting; WAW ordering is the issue stage's responsibility).
- rd_ready reflects the busy state before this cycle's alloc. The issue stage must not read and allocate the same register in the same cycle expecting the post-alloc state.
- par_err_sticky:
  - set at posedge if any par_err bit is 1.
  - cleared by par_err_clr when no par_err bit is 1.
  - set has priority over clear.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - each stored register holds one extra even-parity bit, computed from wr_data at write time.
  - par_err[i]=1 when port i reads from the array (not r0, not bypass) and the recomputed parity mismatches the stored bit.
  - rd_data still returns the stored value.
- Undefined: no parity storage; par_err tied to 0; par_err_sticky held at 0. Ports remain present in both builds.

Test Plan:
- Reset with RESET_VAL=32'hDEAD_BEEF, then read r1 and r31 -> rd_data=32'hDEADBEEF, rd_ready=1; read r0 -> rd_data=0, rd_ready=1.
- Write r5=32'h1234_5678 while port0 reads r5 in the same cycle -> port0 gets 32'h12345678 combinationally; the next cycle it reads from the array with the same value.
- NUM_WR=2: both ports write r7 (port0=32'hAAAA_AAAA, port1=32'h5555_5555) -> same-cycle bypass and the stored value are both 32'h55555555.
- Alloc r9, then next cycle read r9 -> rd_ready=0. Write r9=32'h42 -> rd_ready=1 in the write cycle via bypass and stays 1 after. Alloc plus write r9 together -> after the edge rd_ready=0 and data=32'h42.
- Write r0=32'hFFFF_FFFF with alloc_addr=0 -> r0 reads 0 with rd_ready=1; busy unchanged.
- REGFILE_PARITY_EN: write r3=32'h1, bench forces the stored parity bit inverted, then read r3 -> par_err[0]=1 and par_err_sticky=1 next cycle. Pulse par_err_clr with no error present -> sticky=0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.
// Define REGFILE_PARITY_EN to store an even-parity bit per register and flag read-side parity errors.
module regfile_mp #(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      NUM_REGS  = 32,
    parameter int unsigned      NUM_RD    = 2,
    parameter int unsigned      NUM_WR    = 1,
    parameter logic [XLEN-1:0]  RESET_VAL = '0,
    localparam int unsigned     AW        = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic [NUM_RD-1:0]        par_err,
    output logic                     par_err_sticky,
    input  logic                     par_err_clr
);

    // r0 is hardwired, so storage and scoreboard start at index 1
    logic [XLEN-1:0]     regs_q [1:NUM_REGS-1];
    logic [XLEN-1:0]     regs_d [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] busy_q, busy_d;
    logic [NUM_REGS-1:1] wr_hit;
    logic                sticky_q, sticky_d;
`ifdef REGFILE_PARITY_EN
    logic [NUM_REGS-1:1] par_q, par_d;
`endif

    // Array update: ascending port order lets the highest port win on a collision
    always_comb begin
        regs_d = regs_q;
`ifdef REGFILE_PARITY_EN
        par_d  = par_q;
`endif
        for (int j = 0; j < int'(NUM_WR); j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
`ifdef REGFILE_PARITY_EN
                par_d[wr_addr[j*AW +: AW]]  = ^wr_data[j*XLEN +: XLEN];
`endif
            end
        end
    end

    // Scoreboard: allocation beats writeback in the same cycle
    always_comb begin
        wr_hit = '0;
        busy_d = busy_q;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) wr_hit[r] = 1'b1;
            end
            if (alloc_en && (alloc_addr == AW'(r))) busy_d[r] = 1'b1;
            else if (wr_hit[r])                     busy_d[r] = 1'b0;
        end
    end

    // Read ports: r0, then bypass from the highest matching write port, then the array
    always_comb begin
        logic [AW-1:0]   addr;
        logic            byp;
        logic [XLEN-1:0] byp_data;
        rd_data  = '0;
        rd_ready = '0;
        par_err  = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            addr     = rd_addr[i*AW +: AW];
            byp      = 1'b0;
            byp_data = '0;
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                    byp      = 1'b1;
                    byp_data = wr_data[j*XLEN +: XLEN];
                end
            end
            if (addr == '0) begin
                rd_ready[i] = 1'b1;
            end else if (byp) begin
                rd_data[i*XLEN +: XLEN] = byp_data;
                rd_ready[i]             = 1'b1;
            end else begin
                rd_data[i*XLEN +: XLEN] = regs_q[addr];
                rd_ready[i]             = ~busy_q[addr];
`ifdef REGFILE_PARITY_EN
                par_err[i]              = (^regs_q[addr]) != par_q[addr];
`endif
            end
        end
    end

    // Sticky error: a live error outranks a clear request
    always_comb begin
        sticky_d = sticky_q;
        if (|par_err)         sticky_d = 1'b1;
        else if (par_err_clr) sticky_d = 1'b0;
    end

    assign par_err_sticky = sticky_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                regs_q[r] <= RESET_VAL;
            end
            busy_q   <= '0;
            sticky_q <= 1'b0;
`ifdef REGFILE_PARITY_EN
            par_q    <= {(NUM_REGS-1){^RESET_VAL}};
`endif
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            sticky_q <= sticky_d;
`ifdef REGFILE_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (2 read / 2 write ports): directed vector table, reset and parity
// sequences, then random traffic checked against an array-based reference model.
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam logic [31:0] RV   = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_ready;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic [1:0]  par_err;
    logic        par_err_sticky;
    logic        par_err_clr;

    int total = 0;
    int bad   = 0;

    regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .par_err(par_err), .par_err_sticky(par_err_sticky),
        .par_err_clr(par_err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents and busy flags
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ae;
        logic [4:0]  aa;
        logic [31:0] ed0, ed1;
        logic [1:0]  er;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = (r == 0) ? 32'h0 : RV;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic r);
        if (a == 0) begin
            d = 0; r = 1;
        end else if (wr_en[1] && wr_addr[9:5] == a) begin
            d = wr_data[63:32]; r = 1;
        end else if (wr_en[0] && wr_addr[4:0] == a) begin
            d = wr_data[31:0]; r = 1;
        end else begin
            d = m_reg[a]; r = !m_busy[a];
        end
    endtask

    task automatic model_step();
        for (int j = 0; j < 2; j++) begin
            logic [4:0] a;
            a = wr_addr[j*AW +: AW];
            if (wr_en[j] && a != 0) begin
                m_reg[a] = wr_data[j*XLEN +: XLEN];
                if (!(alloc_en && alloc_addr == a)) m_busy[a] = 1'b0;
            end
        end
        if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    endtask

    task automatic drive(input logic [4:0] ra0, ra1, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic ae, input logic [4:0] aa);
        rd_addr    = {ra1, ra0};
        wr_en      = we;
        wr_addr    = {wa1, wa0};
        wr_data    = {wd1, wd0};
        alloc_en   = ae;
        alloc_addr = aa;
    endtask

    function automatic vec_t mk(logic [4:0] ra0, ra1, logic [1:0] we, logic [4:0] wa0,
                                logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
                                logic ae, logic [4:0] aa, logic [31:0] ed0, ed1, logic [1:0] er);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1;
        v.wd1 = wd1; v.ae = ae; v.aa = aa; v.ed0 = ed0; v.ed1 = ed1; v.er = er;
        return v;
    endfunction

    // Advance one clock edge, keeping the model in step, and return at the next negedge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    vec_t vecs [$];

    initial begin
        reset = 1'b1; par_err_clr = 1'b0;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        //          ra0 ra1 we     wa0 wd0           wa1 wd1           ae  aa  ed0           ed1           er
        vecs.push_back(mk(1, 31, 2'b00, 0, 0,            0, 0,            0, 0,  RV,           RV,           2'b11));
        vecs.push_back(mk(0, 0,  2'b00, 0, 0,            0, 0,            0, 0,  0,            0,            2'b11));
        vecs.push_back(mk(5, 6,  2'b01, 5, 32'h12345678, 0, 0,            0, 0,  32'h12345678, RV,           2'b11));
        vecs.push_back(mk(5, 5,  2'b00, 0, 0,            0, 0,            0, 0,  32'h12345678, 32'h12345678, 2'b11));
        vecs.push_back(mk(7, 7,  2'b11, 7, 32'hAAAAAAAA, 7, 32'h55555555, 0, 0,  32'h55555555, 32'h55555555, 2'b11));
        vecs.push_back(mk(7, 7,  2'b00, 0, 0,            0, 0,            0, 0,  32'h55555555, 32'h55555555, 2'b11));
        vecs.push_back(mk(9, 9,  2'b00, 0, 0,            0, 0,            1, 9,  RV,           RV,           2'b11));
        vecs.push_back(mk(9, 9,  2'b00, 0, 0,            0, 0,            0, 0,  RV,           RV,           2'b00));
        vecs.push_back(mk(9, 9,  2'b01, 9, 32'h42,       0, 0,            0, 0,  32'h42,       32'h42,       2'b11));
        vecs.push_back(mk(9, 9,  2'b00, 0, 0,            0, 0,            0, 0,  32'h42,       32'h42,       2'b11));
        vecs.push_back(mk(9, 9,  2'b10, 0, 0,            9, 32'h42,       1, 9,  32'h42,       32'h42,       2'b11));
        vecs.push_back(mk(9, 9,  2'b00, 0, 0,            0, 0,            0, 0,  32'h42,       32'h42,       2'b00));
        vecs.push_back(mk(0, 9,  2'b01, 0, 32'hFFFFFFFF, 0, 0,            1, 0,  0,            32'h42,       2'b01));
        vecs.push_back(mk(0, 9,  2'b00, 0, 0,            0, 0,            0, 0,  0,            32'h42,       2'b01));
        vecs.push_back(mk(9, 9,  2'b11, 9, 32'h7,        9, 32'h8,        0, 0,  32'h8,        32'h8,        2'b11));
        vecs.push_back(mk(9, 9,  2'b00, 0, 0,            0, 0,            0, 0,  32'h8,        32'h8,        2'b11));
        vecs.push_back(mk(10, 10, 2'b00, 0, 0,           0, 0,            1, 10, RV,           RV,           2'b11));
        vecs.push_back(mk(10, 10, 2'b00, 0, 0,           0, 0,            1, 10, RV,           RV,           2'b00));
        vecs.push_back(mk(10, 10, 2'b00, 0, 0,           0, 0,            0, 0,  RV,           RV,           2'b00));

        foreach (vecs[k]) begin
            drive(vecs[k].ra0, vecs[k].ra1, vecs[k].we, vecs[k].wa0, vecs[k].wd0,
                  vecs[k].wa1, vecs[k].wd1, vecs[k].ae, vecs[k].aa);
            #1;
            chk($sformatf("vec%0d", k),
                128'({rd_data, rd_ready, par_err, par_err_sticky}),
                128'({vecs[k].ed1, vecs[k].ed0, vecs[k].er, 2'b00, 1'b0}));
            tick();
        end

`ifdef REGFILE_PARITY_EN
        drive(0, 0, 2'b01, 3, 32'h1, 0, 0, 1'b0, 0);
        tick();
        force dut.par_q[3] = 1'b0;
        drive(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        #1;
        chk("par_err_on_read", 128'({rd_data[31:0], par_err}), 128'({32'h1, 2'b01}));
        tick();
        #1;
        chk("par_sticky_set", 128'(par_err_sticky), 128'(1'b1));
        drive(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        par_err_clr = 1'b1;
        tick();
        par_err_clr = 1'b0;
        #1;
        chk("par_sticky_clr", 128'(par_err_sticky), 128'(1'b0));
        release dut.par_q[3];
        drive(0, 0, 2'b01, 3, 32'h1, 0, 0, 1'b0, 0);
        tick();
`endif

        // Reset arriving while a write is pending must discard that write
        drive(12, 9, 2'b01, 12, 32'h1234, 0, 0, 1'b1, 12);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(12, 9, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        reset = 1'b0;
        model_reset();
        #1;
        chk("reset_mid_write", 128'({rd_data, rd_ready, par_err_sticky}),
            128'({RV, RV, 2'b11, 1'b0}));

        for (int n = 0; n < 400; n++) begin
            logic [31:0] d0, d1;
            logic        r0, r1;
            drive(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 2'($urandom),
                  5'($urandom_range(0, 15)), $urandom, 5'($urandom_range(0, 15)), $urandom,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)));
            #1;
            model_read(rd_addr[4:0], d0, r0);
            model_read(rd_addr[9:5], d1, r1);
            chk($sformatf("rand%0d", n), 128'({rd_data, rd_ready, par_err}),
                128'({d1, d0, r1, r0, 2'b00}));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
